// File: rtl/logic_block.sv
// Configurable logic block: N LUT-based logic elements with optional flip-flops,
// programmed through a serial shift chain that can be daisy-chained across blocks.
module logic_block #(
  parameter int LUT_INPUTS = 4,
  parameter int NUM_LE     = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           config_en,
  input  logic                           config_data_in,
  output logic                           config_data_out,
  output logic                           cfg_valid,
  input  logic                           le_en,
  input  logic                           le_srst,
  input  logic [NUM_LE*LUT_INPUTS-1:0]   select,
  output logic [NUM_LE-1:0]              le_out
);

  localparam int K     = LUT_INPUTS;
  localparam int DEPTH = 1 << K;
  localparam int CFG_W = DEPTH + 3;
  localparam int TOTAL = NUM_LE * CFG_W;
  localparam int CW    = $clog2(TOTAL + 1);

  localparam logic [CW-1:0] TOTAL_C = CW'(TOTAL);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  logic [TOTAL-1:0]  cfg;
  logic [CW-1:0]     count;
  logic [NUM_LE-1:0] ff;
  logic [NUM_LE-1:0] lut_out;
  logic [NUM_LE-1:0] chain;
  logic [NUM_LE-1:0] init;
  logic [NUM_LE-1:0] reg_mode;
  logic [DEPTH-1:0]  lut [NUM_LE];
  logic [K-1:0]      esel;
  logic              prev;

  // Unpack each element's configuration word into named fields
  for (genvar g = 0; g < NUM_LE; g++) begin : g_fields
    assign chain[g]    = cfg[g*CFG_W + CFG_W - 1];
    assign init[g]     = cfg[g*CFG_W + CFG_W - 2];
    assign reg_mode[g] = cfg[g*CFG_W + CFG_W - 3];
    assign lut[g]      = cfg[g*CFG_W +: DEPTH];
  end

  // The tail of the chain is already a register, so daisy-chaining
  // never creates a combinational path between blocks.
  assign config_data_out = cfg[TOTAL-1];
  assign cfg_valid       = (count == TOTAL_C);

  // Shift chain and bit counter; a shift after a full image starts a new one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg   <= '0;
      count <= '0;
    end else if (config_en) begin
      cfg   <= {cfg[TOTAL-2:0], config_data_in};
      count <= (count == TOTAL_C) ? ONE_C : count + ONE_C;
    end
  end

  // LUT lookup and output muxing; chained elements ripple from i-1 to i
  always_comb begin
    lut_out = '0;
    le_out  = '0;
    esel    = '0;
    prev    = 1'b0;
    for (int i = 0; i < NUM_LE; i++) begin
      esel = select[i*K +: K];
      if (i > 0) begin
        if (chain[i]) esel[0] = prev;
      end
      lut_out[i] = lut[i][esel];
      le_out[i]  = cfg_valid & (reg_mode[i] ? ff[i] : lut_out[i]);
      prev       = le_out[i];
    end
  end

  // Element flip-flops: init while unconfigured or on sync reset, else capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff <= '0;
    end else begin
      for (int i = 0; i < NUM_LE; i++) begin
        if (!cfg_valid)   ff[i] <= init[i];
        else if (le_srst) ff[i] <= init[i];
        else if (le_en)   ff[i] <= lut_out[i];
      end
    end
  end

endmodule

// File: tb/tb_logic_block.sv
// Directed self-checking bench for logic_block (N=4, K=4, 76-bit image).
// Each task drives one scenario and checks its own hand-computed results.
module tb_logic_block;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        config_en = 1'b0;
  logic        config_data_in = 1'b0;
  logic        config_data_out;
  logic        cfg_valid;
  logic        le_en = 1'b0;
  logic        le_srst = 1'b0;
  logic [15:0] select = '0;
  logic [3:0]  le_out;

  int checks = 0;
  int errors = 0;

  logic [75:0] xor_img;

  logic_block #(.LUT_INPUTS(4), .NUM_LE(4)) dut (
    .clk(clk),
    .rst(rst),
    .config_en(config_en),
    .config_data_in(config_data_in),
    .config_data_out(config_data_out),
    .cfg_valid(cfg_valid),
    .le_en(le_en),
    .le_srst(le_srst),
    .select(select),
    .le_out(le_out)
  );

  always #5 clk = ~clk;

  function automatic logic [18:0] w(input logic c, input logic in,
                                    input logic m, input logic [15:0] l);
    return {c, in, m, l};
  endfunction

  task automatic shift_one(input logic b);
    config_data_in = b;
    config_en = 1'b1;
    @(posedge clk); #1;
    config_en = 1'b0;
    config_data_in = 1'b0;
  endtask

  task automatic shift_bits(input logic [75:0] img, input int n);
    for (int b = 75; b > 75 - n; b--) shift_one(img[b]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++;
    if (cfg_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got %b want 0", cfg_valid);
    end
    checks++;
    if (le_out !== 4'b0000) begin
      errors++; $display("FAIL reset_le_out got %b want 0000", le_out);
    end
    checks++;
    if (config_data_out !== 1'b0) begin
      errors++; $display("FAIL reset_dout got %b want 0", config_data_out);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_comb_xor();
    do_reset();
    shift_bits(xor_img, 76);
    checks++;
    if (cfg_valid !== 1'b1) begin
      errors++; $display("FAIL xor_valid got %b want 1", cfg_valid);
    end
    select = {4'b0111, 4'b0011, 4'b1111, 4'b0001};
    #1;
    checks++;
    if (le_out !== 4'b1001) begin
      errors++; $display("FAIL xor_pat1 got %b want 1001", le_out);
    end
    select = {4'b1000, 4'b1010, 4'b1110, 4'b0000};
    #1;
    checks++;
    if (le_out !== 4'b1010) begin
      errors++; $display("FAIL xor_pat2 got %b want 1010", le_out);
    end
  endtask

  task automatic test_partial();
    do_reset();
    select = {4'b0111, 4'b0011, 4'b1111, 4'b0001};
    shift_bits(xor_img, 75);
    checks++;
    if (cfg_valid !== 1'b0) begin
      errors++; $display("FAIL partial_valid got %b want 0", cfg_valid);
    end
    checks++;
    if (le_out !== 4'b0000) begin
      errors++; $display("FAIL partial_le_out got %b want 0000", le_out);
    end
    shift_one(xor_img[0]);
    checks++;
    if (cfg_valid !== 1'b1) begin
      errors++; $display("FAIL partial_final_valid got %b want 1", cfg_valid);
    end
    checks++;
    if (le_out !== 4'b1001) begin
      errors++; $display("FAIL partial_final_out got %b want 1001", le_out);
    end
  endtask

  task automatic test_registered();
    logic [75:0] img;
    do_reset();
    le_en = 1'b0;
    select = '0;
    img = {w(0,0,0,16'h0), w(0,0,0,16'h0), w(0,0,0,16'h0),
           w(0,1,1,16'h0001)};
    shift_bits(img, 76);
    checks++;
    if (le_out[0] !== 1'b0) begin
      errors++; $display("FAIL reg_after_load got %b want 0", le_out[0]);
    end
    le_en = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (le_out[0] !== 1'b1) begin
      errors++; $display("FAIL reg_capture got %b want 1", le_out[0]);
    end
    le_en = 1'b0;
    select = 16'h0001;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (le_out[0] !== 1'b1) begin
      errors++; $display("FAIL reg_hold got %b want 1", le_out[0]);
    end
    le_en = 1'b1;
    le_srst = 1'b1;
    @(posedge clk); #1;
    le_srst = 1'b0;
    le_en = 1'b0;
    checks++;
    if (le_out[0] !== 1'b1) begin
      errors++; $display("FAIL reg_srst_init1 got %b want 1", le_out[0]);
    end
    img = {w(0,0,0,16'h0), w(0,0,0,16'h0), w(0,0,0,16'h0),
           w(0,0,1,16'h0001)};
    shift_bits(img, 76);
    select = 16'h0000;
    le_en = 1'b1;
    @(posedge clk); #1;
    le_en = 1'b0;
    checks++;
    if (le_out[0] !== 1'b1) begin
      errors++; $display("FAIL reg_recapture got %b want 1", le_out[0]);
    end
    le_srst = 1'b1;
    @(posedge clk); #1;
    le_srst = 1'b0;
    checks++;
    if (le_out[0] !== 1'b0) begin
      errors++; $display("FAIL reg_srst_init0 got %b want 0", le_out[0]);
    end
  endtask

  task automatic test_chain();
    logic [75:0] img;
    do_reset();
    img = {w(0,0,0,16'h0), w(0,0,0,16'h0), w(1,0,0,16'hAAAA),
           w(0,0,0,16'hAAAA)};
    shift_bits(img, 76);
    select = 16'h0001;
    #1;
    checks++;
    if (le_out[1:0] !== 2'b11) begin
      errors++; $display("FAIL chain_hi got %b want 11", le_out[1:0]);
    end
    select = 16'h0010;
    #1;
    checks++;
    if (le_out[1:0] !== 2'b00) begin
      errors++; $display("FAIL chain_lo got %b want 00", le_out[1:0]);
    end
    select = 16'h0011;
    #1;
    checks++;
    if (le_out[1:0] !== 2'b11) begin
      errors++; $display("FAIL chain_both got %b want 11", le_out[1:0]);
    end
  endtask

  task automatic test_daisy();
    logic [75:0] a;
    logic [75:0] b;
    do_reset();
    a = {w(1,0,1,16'h1234), w(0,1,0,16'hBEEF), w(1,1,0,16'h0F0F),
         w(0,0,1,16'hCAFE)};
    b = {w(0,1,1,16'h5A5A), w(1,0,0,16'h3C3C), w(0,1,1,16'h9999),
         w(1,1,1,16'h0001)};
    shift_bits(a, 76);
    checks++;
    if (cfg_valid !== 1'b1) begin
      errors++; $display("FAIL daisy_valid76 got %b want 1", cfg_valid);
    end
    for (int k = 0; k < 76; k++) begin
      checks++;
      if (config_data_out !== a[75-k]) begin
        errors++;
        $display("FAIL daisy_dout bit %0d got %b want %b",
                 k, config_data_out, a[75-k]);
      end
      shift_one(b[75-k]);
      if (k == 0) begin
        checks++;
        if (cfg_valid !== 1'b0) begin
          errors++; $display("FAIL daisy_valid77 got %b want 0", cfg_valid);
        end
      end
      if (k == 74) begin
        checks++;
        if (cfg_valid !== 1'b0) begin
          errors++; $display("FAIL daisy_valid151 got %b want 0", cfg_valid);
        end
      end
    end
    checks++;
    if (cfg_valid !== 1'b1) begin
      errors++; $display("FAIL daisy_valid152 got %b want 1", cfg_valid);
    end
    checks++;
    if (config_data_out !== b[75]) begin
      errors++;
      $display("FAIL daisy_tail got %b want %b", config_data_out, b[75]);
    end
  endtask

  task automatic test_reset_midload();
    logic [75:0] ones;
    ones = '1;
    do_reset();
    shift_bits(ones, 76);
    shift_bits(xor_img, 40);
    checks++;
    if (config_data_out !== 1'b1 || cfg_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_pre got dout=%b valid=%b want dout=1 valid=0",
               config_data_out, cfg_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (cfg_valid !== 1'b0 || le_out !== 4'b0000 ||
        config_data_out !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst got valid=%b out=%b dout=%b want 0 0000 0",
               cfg_valid, le_out, config_data_out);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    select = {4'b0111, 4'b0011, 4'b1111, 4'b0001};
    shift_bits(xor_img, 75);
    checks++;
    if (cfg_valid !== 1'b0) begin
      errors++; $display("FAIL mid_reload75 got %b want 0", cfg_valid);
    end
    shift_one(xor_img[0]);
    checks++;
    if (cfg_valid !== 1'b1 || le_out !== 4'b1001) begin
      errors++;
      $display("FAIL mid_reload got valid=%b out=%b want 1 1001",
               cfg_valid, le_out);
    end
  endtask

  initial begin
    xor_img = {w(0,0,0,16'h6996), w(0,0,0,16'h6996),
               w(0,0,0,16'h6996), w(0,0,0,16'h6996)};
    test_reset();
    test_comb_xor();
    test_partial();
    test_registered();
    test_chain();
    test_daisy();
    test_reset_midload();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/logic_block.md
LOGIC_BLOCK -- requirements
Module: logic_block

Interface
REQ-001 Parameter LUT_INPUTS, default 4, select inputs per logic element (K); LUT depth 2^K.
REQ-002 Parameter NUM_LE, default 4, number of logic elements (N) in the block.
REQ-003 Derived CFG_W = 2^K + 3 bits per element; derived TOTAL = N*CFG_W chain length.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 config_en  input  1  shift-enable for the configuration chain.
REQ-007 config_data_in  input  1  serial configuration bit, image streamed MSB first.
REQ-008 config_data_out  output  1  chain tail bit, for daisy-chaining blocks.
REQ-009 cfg_valid  output  1  high when a complete TOTAL-bit image is loaded.
REQ-010 le_en  input  1  common flip-flop enable.
REQ-011 le_srst  input  1  synchronous load of each flip-flop with its init bit.
REQ-012 select  input  N*K  element i uses select[i*K +: K].
REQ-013 le_out  output  N  element outputs.

Function
REQ-014 Chain register cfg[TOTAL-1:0]: on a clk edge with config_en=1, cfg <= {cfg[TOTAL-2:0], config_data_in}; with config_en=0 it holds.
REQ-015 config_data_out = cfg[TOTAL-1], registered, no combinational path from config_data_in.
REQ-016 Element i word = cfg[i*CFG_W +: CFG_W], fields MSB to LSB: chain(1), init(1), reg_mode(1), lut(2^K).
REQ-017 Bit counter, width clog2(TOTAL+1): increments on each config_en=1 edge; count==TOTAL with config_en=1 reloads it to 1 (new image starts).
REQ-018 cfg_valid = (count==TOTAL); cfg_valid is 0 from the first shift of a new image until its TOTAL-th shift completes.
REQ-019 Effective select of element i: its select slice, except when chain=1 and i>0, bit 0 is replaced by le_out[i-1]; chain is ignored for element 0.
REQ-020 lut_out[i] = lut[effective select]; purely combinational.
REQ-021 Flip-flop priority per edge: !cfg_valid -> ff <= init; else le_srst -> ff <= init; else le_en -> ff <= lut_out; else hold.
REQ-022 le_out[i] = cfg_valid ? (reg_mode ? ff[i] : lut_out[i]) : 0.
REQ-023 Registered-mode latency: one clk edge from select change to le_out change; combinational mode has zero-cycle latency.
REQ-024 A chained registered element sees the predecessor's le_out; combinational chains ripple in the same cycle.
REQ-025 Combinational loops are impossible, because chaining is strictly i-1 to i.
REQ-026 config_en=1 and le_srst/le_en in the same cycle: the shift happens; cfg_valid falls only if it was a restart (REQ-017); flip-flops follow REQ-021 using pre-edge cfg_valid.

Reset
REQ-027 rst=1 asynchronously clears cfg, count, all ff, and config_data_out to 0; cfg_valid=0 and le_out=0 immediately.
REQ-028 rst asserted mid-load discards partial image; after release, a full TOTAL-bit load is required before cfg_valid=1.
REQ-029 Release of rst takes effect at the next clk edge; no state changes while rst=1.

Verification (N=4, K=4, CFG_W=19, TOTAL=76)
REQ-030 Comb XOR: load all elements with lut[j]=^j, chain=0, reg_mode=0 -> cfg_valid=1 after the 76th shift; select slice 4'b0111 -> le_out bit=1, 4'b0011 -> 0, within same cycle.
REQ-031 Partial load: 75 shifts -> cfg_valid=0, le_out=0000; one more shift -> cfg_valid=1.
REQ-032 Registered/hold: reg_mode=1, init=1, lut=16'h0001, select=0, le_en=1 -> le_out=1 after one edge; le_en=0, select=1 for 5 edges -> le_out stays 1; le_srst=1 -> 1 (init); set init=0 and reload -> le_srst forces 0.
REQ-033 Chain: element 0 comb identity on bit0 (lut=16'hAAAA), element 1 chain=1 lut=16'hAAAA -> toggling select[0] toggles le_out[1] same cycle regardless of select[4].
REQ-034 Daisy: shift 76-bit image then 76 more bits -> config_data_out reproduces the first image MSB first; cfg_valid drops at bit 77 and rises at bit 152.
REQ-035 Reset mid-load: rst at shift 40 -> cfg_valid=0, le_out=0000, config_data_out=0 asynchronously; full reload restores REQ-030 results.
